ksa_swap: RTL and testbench

- Second RC4 stage: runs the key-scheduling pass over the 256-byte S memory after the initialiser has written s[i]=i.
- Performs, for i = 0..255: j = j + s[i] + key[i mod KEY_BYTES]; swap s[i] and s[j].
- Shares the single-port S RAM with the initialiser through a top-level mux. The mux hands the port to this block once the initialiser signals completion.
- Its done pulse starts the PRGA/decrypt stage.

---
 rtl/ksa_swap.sv | 109 ++++++++++
 tb/tb_ksa_swap.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ksa_swap.sv
// ksa_swap: RC4 key-scheduling pass (j += s[i] + key; swap s[i], s[j]) over a 256-byte single-port S RAM.
// Optional: `define KSA_SKIP_SELF_SWAP_EN to skip both writes when i == j.
module ksa_swap #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   write_enable,
  input  logic [7:0]             q,
  output logic                   busy,
  output logic                   done
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  typedef enum logic [3:0] {
    S_IDLE, S_RD_I, S_LATCH_I, S_RD_J, S_LATCH_J, S_WR_I, S_WR_J, S_NEXT, S_DONE
  } state_t;
  state_t                 r_state;
  logic [7:0]             r_i, r_j, r_si;
  logic [KW-1:0]          r_kidx;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [8*KEY_BYTES-1:0] w_key_sh;
  logic [7:0]             w_kbyte, w_jn;
  logic [KW-1:0]          w_kidx_nx;
  logic                   w_skip;
  // key[0] is the MSB byte, so shift the selected byte up to the top
  assign w_key_sh  = r_key << (8 * r_kidx);
  assign w_kbyte   = w_key_sh[8*KEY_BYTES-1 -: 8];
  assign w_jn      = r_j + q + w_kbyte;
  assign w_kidx_nx = (r_kidx == KW'(KEY_BYTES - 1)) ? '0 : r_kidx + 1'b1;
`ifdef KSA_SKIP_SELF_SWAP_EN
  assign w_skip = (r_j == r_i);
`else
  assign w_skip = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_si         <= '0;
      r_kidx       <= '0;
      r_key        <= '0;
      address      <= '0;
      data         <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RD_I;
          r_key   <= secret_key;
          r_i     <= '0;
          r_j     <= '0;
          r_kidx  <= '0;
          address <= '0;
          busy    <= 1'b1;
        end
        S_RD_I:    r_state <= S_LATCH_I;
        S_LATCH_I: begin
          r_si    <= q;
          r_j     <= w_jn;
          address <= w_jn;
          r_state <= S_RD_J;
        end
        S_RD_J:    r_state <= S_LATCH_J;
        S_LATCH_J: if (w_skip) r_state <= S_NEXT;
        else begin
          address      <= r_i;
          data         <= q;
          write_enable <= 1'b1;
          r_state      <= S_WR_I;
        end
        S_WR_I: begin
          address <= r_j;
          data    <= r_si;
          r_state <= S_WR_J;
        end
        S_WR_J: begin
          write_enable <= 1'b0;
          r_state      <= S_NEXT;
        end
        S_NEXT: if (r_i == 8'd255) begin
          r_i     <= '0;
          r_j     <= '0;
          r_kidx  <= '0;
          address <= '0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_i     <= r_i + 8'd1;
          r_kidx  <= w_kidx_nx;
          address <= r_i + 8'd1;
          r_state <= S_RD_I;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_swap.sv
// tb_ksa_swap: scoreboard bench for ksa_swap with a behavioural synchronous S RAM and a software KSA model.
module tb_ksa_swap;
  logic        clk = 0, reset_n = 0, start = 0, load = 0;
  logic [23:0] secret_key = '0;
  logic [7:0]  address, data, q;
  logic        write_enable, busy, done;
  logic [7:0]  mem [256];
  logic [7:0]  exp_s [256];
  logic [15:0] exp_q [$];
  logic [15:0] wlog [$];
  int errors = 0, checks = 0, wcnt = 0, dcnt = 0;

  always #5 clk = ~clk;

  ksa_swap #(.KEY_BYTES(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .address(address), .data(data), .write_enable(write_enable), .q(q),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (load) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    else if (write_enable) mem[address] <= data;
    q <= mem[address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && write_enable) begin
      wlog.push_back({address, data});
      if (exp_q.size() == 0) chk("write_unexpected", {address, data}, 32'hFFFF_FFFF);
      else chk("write_addr_data", {address, data}, exp_q.pop_front());
      wcnt++;
    end
    if (done === 1'b1) dcnt++;
  end

  task automatic build(input logic [23:0] key, output int selfs, output int wr40);
    logic [7:0] s [256];
    logic [7:0] jj, t;
    bit skip;
    int nw;
    jj = 0; selfs = 0; wr40 = 0; nw = 0;
    for (int i = 0; i < 256; i++) s[i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      if (i == 40) wr40 = nw;
      jj = jj + s[i] + key[23 - 8*(i % 3) -: 8];
      if (jj == 8'(i)) selfs++;
`ifdef KSA_SKIP_SELF_SWAP_EN
      skip = (jj == 8'(i));
`else
      skip = 0;
`endif
      if (!skip) begin
        exp_q.push_back({8'(i), s[jj]});
        exp_q.push_back({jj, s[i]});
        nw += 2;
      end
      t = s[i]; s[i] = s[jj]; s[jj] = t;
    end
    for (int i = 0; i < 256; i++) exp_s[i] = s[i];
  endtask

  task automatic load_identity();
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
  endtask

  task automatic run_ksa(input logic [23:0] key, input bit poke);
    int selfs, wr40, n, dbase, bad;
    bit got;
    load_identity();
    build(key, selfs, wr40);
    dbase = dcnt;
    secret_key = key;
    start = 1;
    n = 0; got = 0;
    while (n < 3000 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = poke && n == 99;
      if (n == 1) chk("busy_after_accept", busy, 1);
      if (n == 50) secret_key = ~key;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    // n counts the accept edge as edge 1
`ifdef KSA_SKIP_SELF_SWAP_EN
    chk("done_latency", n, 1 + 7*256 - 2*selfs);
`else
    chk("done_latency", n, 1 + 7*256);
`endif
    start = poke;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    repeat (20) @(negedge clk);
    chk("no_restart_busy", busy, 0);
    chk("done_count", dcnt - dbase, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
    chk("final_s_mismatches", bad, 0);
  endtask

  initial begin
    int wbase, selfs, wr40, n, dbase;
    logic [15:0] tbl [8];
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", write_enable, 0);
    reset_n = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_outputs", {busy, done, write_enable, address}, 0);
    end

    // zero key: hand-derived first writes
`ifdef KSA_SKIP_SELF_SWAP_EN
    tbl = '{16'h0203, 16'h0302, 16'h0305, 16'h0502, 0, 0, 0, 0};
`else
    tbl = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302, 16'h0305, 16'h0502};
`endif
    wbase = wcnt;
    run_ksa(24'h000000, 0);
`ifdef KSA_SKIP_SELF_SWAP_EN
    for (int k = 0; k < 4; k++) chk("zero_key_first_writes", wlog[wbase + k], tbl[k]);
`else
    for (int k = 0; k < 8; k++) chk("zero_key_first_writes", wlog[wbase + k], tbl[k]);
`endif

    run_ksa(24'h035F3C, 1);

    // reset in the WR_I cycle of iteration 40
    load_identity();
    build(24'h035F3C, selfs, wr40);
    wbase = wcnt;
    dbase = dcnt;
    secret_key = 24'h035F3C;
    start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (n < 2000 && (wcnt - wbase) != wr40 + 1) begin
      @(negedge clk);
      #1 n++;
    end
    chk("reached_iter40", (wcnt - wbase), wr40 + 1);
    chk("iter40_wr_i_addr", address, 40);
    reset_n = 0;
    @(negedge clk);
    chk("midrun_rst_outputs", {busy, done, write_enable, address}, 0);
    reset_n = 1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("midrun_rst_idle", {busy, write_enable}, 0);
    chk("midrun_no_done", dcnt - dbase, 0);
    run_ksa(24'h035F3C, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
